// File: rtl/ex_stage_md_pkg.sv
// Shared execute-stage types: ALU opcode, RV32M op encoding and the M-unit FSM state.
package ex_stage_md_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SLL = 3'b001,
        ALU_SRA = 3'b010,
        ALU_SUB = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SRL = 3'b101,
        ALU_OR  = 3'b110,
        ALU_AND = 3'b111
    } alu_ops_t;

    // Encoding follows RV32M funct3 so decode can pass it straight through.
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } ex_md_state_t;

    function automatic logic md_is_div(input md_op_t op);
        return op[2];
    endfunction

    function automatic logic md_is_rem(input md_op_t op);
        return op[2] & op[1];
    endfunction

    function automatic logic md_is_signed_div(input md_op_t op);
        return op[2] & !op[0];
    endfunction

endpackage

// File: rtl/ex_stage_md_if.sv
// ID/EX -> EX/MEM handshake bundle for the execute stage with M-extension.
interface ex_stage_md_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 64
) ();
    logic                        in_valid;
    logic                        in_ready;
    logic                        in_is_md;
    ex_stage_md_pkg::alu_ops_t   in_aluop;
    ex_stage_md_pkg::md_op_t     in_mdop;
    logic [XLEN-1:0]             in_a;
    logic [XLEN-1:0]             in_b;
    logic [TAG_W-1:0]            in_tag;
    logic                        flush;
    logic                        out_valid;
    logic                        out_ready;
    logic [XLEN-1:0]             out_result;
    logic [TAG_W-1:0]            out_tag;
    logic                        busy;

    modport master (
        output in_valid, in_is_md, in_aluop, in_mdop, in_a, in_b, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_result, out_tag, busy
    );

    modport slave (
        input  in_valid, in_is_md, in_aluop, in_mdop, in_a, in_b, in_tag, flush, out_ready,
        output in_ready, out_valid, out_result, out_tag, busy
    );
endinterface

// File: rtl/ex_stage_md_div_iter.sv
// Restoring divider datapath: loads magnitudes on start, one quotient bit per step,
// sign-corrected quotient/remainder presented combinationally from the registers.
module md_div_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            step,
    input  logic            signed_op,
    input  logic            rem_op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] result_c
);
    logic [XLEN-1:0] rem_q, quo_q, dsr_q;
    logic            neg_quo_q, neg_rem_q, rem_sel_q;
    logic            a_neg_c, b_neg_c;
    logic [XLEN:0]   shifted_c, trial_c;

    assign a_neg_c   = signed_op & dividend[XLEN-1];
    assign b_neg_c   = signed_op & divisor[XLEN-1];
    // Remainder stays below the divisor, so one extra bit holds the shifted partial remainder.
    assign shifted_c = {rem_q, quo_q[XLEN-1]};
    assign trial_c   = shifted_c - {1'b0, dsr_q};

    always_ff @(posedge clk or negedge rst_n) begin : div_regs
        if (!rst_n) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_sel_q <= 1'b0;
        end else if (start) begin
            rem_q     <= '0;
            quo_q     <= a_neg_c ? -dividend : dividend;
            dsr_q     <= b_neg_c ? -divisor : divisor;
            neg_quo_q <= a_neg_c ^ b_neg_c;
            neg_rem_q <= a_neg_c;
            rem_sel_q <= rem_op;
        end else if (step) begin
            rem_q <= trial_c[XLEN] ? shifted_c[XLEN-1:0] : trial_c[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], !trial_c[XLEN]};
        end
    end

    always_comb begin : sign_fix
        result_c = '0;
        if (rem_sel_q) result_c = neg_rem_q ? -rem_q : rem_q;
        else           result_c = neg_quo_q ? -quo_q : quo_q;
    end
endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: single-cycle ALU plus RV32M multiply (fixed latency) and iterative divide,
// with valid/ready on both sides and flush for mispredict recovery.
module ex_stage_md
    import ex_stage_md_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned TAG_W   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    ex_stage_md_if.slave bus
);
    localparam int unsigned SH_W    = $clog2(XLEN);
    localparam int unsigned CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int unsigned PW      = 2 * XLEN;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    ex_md_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    md_op_t           op_q;
    logic [XLEN-1:0]  a_q, b_q;
    logic [TAG_W-1:0] op_tag_q;
    logic             out_valid_q;
    logic [XLEN-1:0]  result_q;
    logic [TAG_W-1:0] tag_q;

    logic             in_ready_c, accept_c, xfer_c;
    logic             div_zero_c, div_ovf_c, div_special_c;
    logic [XLEN-1:0]  div_special_val_c, div_res_c, load_val_c;
    logic [TAG_W-1:0] load_tag_c;
    logic             load_c, latch_c, start_mul_c, div_start_c, div_step_c;

    function automatic logic [XLEN-1:0] alu(input alu_ops_t op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SLL: return a << b[SH_W-1:0];
            ALU_SRA: return XLEN'($unsigned($signed(a) >>> b[SH_W-1:0]));
            ALU_SUB: return a - b;
            ALU_XOR: return a ^ b;
            ALU_SRL: return a >> b[SH_W-1:0];
            ALU_OR:  return a | b;
            ALU_AND: return a & b;
            default: return '0;
        endcase
    endfunction

    // Full-width product of sign/zero-extended operands; low or high half by op.
    function automatic logic [XLEN-1:0] mul_res(input md_op_t op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic [PW-1:0] ae, be, p;
        ae = (op == MD_MULH || op == MD_MULHSU) ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
        be = (op == MD_MULH) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
        p  = ae * be;
        return (op == MD_MUL) ? p[XLEN-1:0] : p[PW-1:XLEN];
    endfunction

    assign in_ready_c = (state == ST_IDLE) & (!out_valid_q | bus.out_ready);
    assign accept_c   = bus.in_valid & in_ready_c & !bus.flush;
    assign xfer_c     = out_valid_q & bus.out_ready;

    // Divide-by-zero and signed overflow bypass the iterative divider.
    assign div_zero_c    = (bus.in_b == '0);
    assign div_ovf_c     = md_is_signed_div(bus.in_mdop) & (bus.in_a == MOST_NEG) & (bus.in_b == '1);
    assign div_special_c = md_is_div(bus.in_mdop) & (div_zero_c | div_ovf_c);
    assign div_special_val_c = md_is_rem(bus.in_mdop) ? (div_zero_c ? bus.in_a : '0)
                                                      : (div_zero_c ? '1 : MOST_NEG);

    md_div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start_c),
        .step      (div_step_c),
        .signed_op (md_is_signed_div(bus.in_mdop)),
        .rem_op    (md_is_rem(bus.in_mdop)),
        .dividend  (bus.in_a),
        .divisor   (bus.in_b),
        .result_c  (div_res_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin : next_state_comb
        state_nxt = state;
        if (bus.flush) state_nxt = ST_IDLE;
        else begin
            case (state)
                ST_IDLE: begin
                    if (start_mul_c)      state_nxt = ST_MUL;
                    else if (div_start_c) state_nxt = ST_DIV;
                end
                ST_MUL, ST_DIV: if (load_c) state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Divide counter starts at XLEN: XLEN step cycles, then the sign-fixed result loads at zero.
    always_comb begin : ctrl_comb
        load_c      = 1'b0;
        load_val_c  = '0;
        load_tag_c  = op_tag_q;
        latch_c     = 1'b0;
        start_mul_c = 1'b0;
        div_start_c = 1'b0;
        div_step_c  = 1'b0;
        cnt_nxt     = cnt;
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    latch_c    = 1'b1;
                    load_tag_c = bus.in_tag;
                    if (!bus.in_is_md) begin
                        load_c     = 1'b1;
                        load_val_c = alu(bus.in_aluop, bus.in_a, bus.in_b);
                    end else if (!md_is_div(bus.in_mdop)) begin
                        if (MUL_LAT == 1) begin
                            load_c     = 1'b1;
                            load_val_c = mul_res(bus.in_mdop, bus.in_a, bus.in_b);
                        end else begin
                            start_mul_c = 1'b1;
                            cnt_nxt     = CNT_W'(MUL_LAT - 1);
                        end
                    end else if (div_special_c) begin
                        load_c     = 1'b1;
                        load_val_c = div_special_val_c;
                    end else begin
                        div_start_c = 1'b1;
                        cnt_nxt     = CNT_W'(XLEN);
                    end
                end
            end
            ST_MUL: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt_nxt == '0) begin
                    load_c     = 1'b1;
                    load_val_c = mul_res(op_q, a_q, b_q);
                end
            end
            ST_DIV: begin
                if (cnt == '0) begin
                    load_c     = 1'b1;
                    load_val_c = div_res_c;
                end else begin
                    div_step_c = 1'b1;
                    cnt_nxt    = cnt - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : operand_reg
        if (!rst_n) begin
            op_q     <= MD_MUL;
            a_q      <= '0;
            b_q      <= '0;
            op_tag_q <= '0;
        end else if (latch_c) begin
            op_q     <= bus.in_mdop;
            a_q      <= bus.in_a;
            b_q      <= bus.in_b;
            op_tag_q <= bus.in_tag;
        end
    end

    // Flush beats a result load; a load beats the clear from a same-cycle transfer.
    always_ff @(posedge clk or negedge rst_n) begin : out_reg
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            tag_q       <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (load_c) begin
            out_valid_q <= 1'b1;
            result_q    <= load_val_c;
            tag_q       <= load_tag_c;
        end else if (xfer_c) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = result_q;
    assign bus.out_tag    = tag_q;
    assign bus.busy       = (state == ST_MUL) | (state == ST_DIV);
endmodule
